// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction store with 1-cycle registered fetch, stall and range flag.
// Optional per-word even parity storage and checking: define INSTR_PARITY_EN.
module instruction_memory_loadable #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 10,
    parameter int                DEPTH     = 1024,
    parameter logic [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}}
) (
    input  logic              CLK_SYS,
    input  logic              RST_SYS,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              addr_err,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              parity_err
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              parity_err_r;
    logic              pc_in_range_s;
    logic              load_accept_s;
    logic              load_end_s;
    logic [ADDR_W:0]   count_next_s;
    logic [ADDR_W-1:0] load_ptr_s;

`ifdef INSTR_PARITY_EN
    logic par_r [DEPTH];

    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    // Parity bit is captured alongside each loaded word
    always_ff @(posedge CLK_SYS) begin
        if (!RST_SYS && load_accept_s) begin
            par_r[load_ptr_s] <= even_parity(load_data);
        end
    end
`endif

    // Load handshake decode; the write pointer is simply the running word count
    always_comb begin
        pc_in_range_s = ({1'b0, pc} < DEPTH_C);
        load_accept_s = (state_r == ST_LOAD) && load_valid && load_ready;
        count_next_s  = load_count + {{ADDR_W{1'b0}}, 1'b1};
        load_ptr_s    = load_count[ADDR_W-1:0];
        if (load_accept_s) begin
            load_end_s = load_last || (count_next_s == DEPTH_C);
        end else begin
            load_end_s = 1'b0;
        end
    end

    // Program store write port; contents survive reset
    always_ff @(posedge CLK_SYS) begin
        if (!RST_SYS && load_accept_s) begin
            mem_r[load_ptr_s] <= load_data;
        end
    end

    // Mode FSM with registered fetch and load status outputs
    always_ff @(posedge CLK_SYS) begin
        if (RST_SYS) begin
            state_r      <= ST_RUN;
            instruction  <= NOP_INSTR;
            instr_valid  <= 1'b0;
            addr_err     <= 1'b0;
            load_ready   <= 1'b0;
            load_done    <= 1'b0;
            load_count   <= {(ADDR_W + 1){1'b0}};
            parity_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    load_done <= 1'b0;
                    if (load_start) begin
                        // Load request wins over a same-cycle fetch
                        state_r      <= ST_LOAD;
                        load_ready   <= 1'b1;
                        load_count   <= {(ADDR_W + 1){1'b0}};
                        instruction  <= NOP_INSTR;
                        instr_valid  <= 1'b0;
                        addr_err     <= 1'b0;
                        parity_err_r <= 1'b0;
                    end else if (fetch_en) begin
                        if (pc_in_range_s) begin
                            instruction  <= mem_r[pc];
                            instr_valid  <= 1'b1;
                            addr_err     <= 1'b0;
`ifdef INSTR_PARITY_EN
                            parity_err_r <= (^mem_r[pc]) ^ par_r[pc];
`else
                            parity_err_r <= 1'b0;
`endif
                        end else begin
                            instruction  <= NOP_INSTR;
                            instr_valid  <= 1'b0;
                            addr_err     <= 1'b1;
                            parity_err_r <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_accept_s) begin
                        load_count <= count_next_s;
                        if (load_end_s) begin
                            state_r    <= ST_DONE;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    load_done <= 1'b0;
                    state_r   <= ST_RUN;
                end
                default: begin
                    state_r    <= ST_RUN;
                    load_ready <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

    assign parity_err = parity_err_r;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Self-checking bench for instruction_memory_loadable (DEPTH=16, ADDR_W=5) against a word-array model.
module tb_instruction_memory_loadable;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              CLK_SYS = 1'b0;
    logic              RST_SYS;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              addr_err;
    logic              load_start;
    logic              load_valid;
    logic              load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              parity_err;

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int          fail_cnt  = 0;
    int          flip_pc   = -1;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] stim [32];

    instruction_memory_loadable #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_INSTR(NOP)
    ) dut (
        .CLK_SYS(CLK_SYS), .RST_SYS(RST_SYS), .pc(pc), .fetch_en(fetch_en),
        .instruction(instruction), .instr_valid(instr_valid), .addr_err(addr_err),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count), .parity_err(parity_err)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        logic        in_range;
        logic [31:0] exp_i;
        in_range = (int'(a) < DEPTH);
        exp_i    = in_range ? model_mem[a[3:0]] : NOP;
        pc       = a;
        fetch_en = 1'b1;
        tick();
        check("fetch_instr", instruction, exp_i);
        check("fetch_valid", instr_valid, in_range);
        check("fetch_addr_err", addr_err, !in_range);
        check("fetch_parity", parity_err, (int'(a) == flip_pc));
    endtask

    // Streams stim[0..n-1]; load_last on word last_idx (-1 = none)
    task automatic do_load(input int n, input int last_idx, input bit gaps);
        int stop;
        int done_seen;
        stop = (last_idx >= 0) ? last_idx + 1 : n;
        if (stop > DEPTH) stop = DEPTH;
        load_start = 1'b1;
        fetch_en   = 1'b1;
        pc         = ADDR_W'($urandom_range(0, 15));
        tick();
        load_start = 1'b0;
        check("start_ready", load_ready, 1'b1);
        check("start_nop", {instr_valid, instruction}, {1'b0, NOP});
        check("start_count", load_count, 0);
        done_seen = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                load_valid = 1'b0;
                tick();
                done_seen += int'(load_done);
            end
            load_valid = 1'b1;
            load_data  = stim[i];
            load_last  = (i == last_idx);
            tick();
            done_seen += int'(load_done);
            if (i < stop) model_mem[i] = stim[i];
            if (i == stop - 1) begin
                check("ready_drop", load_ready, 1'b0);
                check("load_no_fetch", {instr_valid, instruction}, {1'b0, NOP});
                fetch_en = 1'b0;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_en   = 1'b0;
        repeat (3) begin
            tick();
            done_seen += int'(load_done);
        end
        check("done_pulses", done_seen, 1);
        check("load_count", load_count, stop);
        check("ready_idle", load_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_SYS    = 1'b1;
        pc         = '0;
        fetch_en   = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        tick();
        tick();
        check("rst_instr", instruction, NOP);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_ready", load_ready, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_count", load_count, 0);
        check("rst_parity", parity_err, 1'b0);
        RST_SYS = 1'b0;

        // Directed three-word program, then back-to-back fetch
        stim[0] = 32'h18A7_1900;
        stim[1] = 32'h1405_0A32;
        stim[2] = 32'h1C53_1CFF;
        do_load(3, 2, 1'b0);
        fetch(5'd0);
        fetch(5'd1);
        fetch(5'd2);

        // Stall holds the previous fetch result
        fetch(5'd1);
        fetch_en = 1'b0;
        pc       = 5'd2;
        repeat (3) begin
            tick();
            check("stall_instr", instruction, model_mem[1]);
            check("stall_valid", instr_valid, 1'b1);
        end
        fetch(5'd2);

        // First fetch after reset lands one cycle later
        RST_SYS  = 1'b1;
        fetch_en = 1'b1;
        pc       = 5'd0;
        tick();
        check("post_rst_instr", instruction, NOP);
        check("post_rst_valid", instr_valid, 1'b0);
        RST_SYS = 1'b0;
        fetch(5'd0);

        // Overflow: 20 words offered, only DEPTH accepted
        for (int i = 0; i < 20; i++) stim[i] = $urandom;
        do_load(20, -1, 1'b0);
        for (int i = 0; i < DEPTH; i++) fetch(ADDR_W'(i));

        // Out-of-range then in-range
        fetch(5'd16);
        fetch(5'd3);
        fetch(5'd31);

        // Random partial load with idle gaps, then random fetches
        for (int i = 0; i < 12; i++) stim[i] = $urandom;
        do_load(12, int'($urandom_range(3, 9)), 1'b1);
        for (int i = 0; i < 24; i++) fetch(ADDR_W'($urandom_range(0, 31)));

        // Reset mid-load keeps the words already written
        for (int i = 0; i < 5; i++) stim[i] = $urandom;
        load_start = 1'b1;
        fetch_en   = 1'b0;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = stim[i];
            tick();
            model_mem[i] = stim[i];
        end
        load_valid = 1'b0;
        RST_SYS    = 1'b1;
        tick();
        RST_SYS = 1'b0;
        check("midrst_ready", load_ready, 1'b0);
        check("midrst_count", load_count, 0);
        check("midrst_done", load_done, 1'b0);
        check("midrst_valid", instr_valid, 1'b0);
        fetch(5'd0);
        fetch(5'd1);
        fetch(5'd2);

`ifdef INSTR_PARITY_EN
        dut.par_r[5] = ~dut.par_r[5];
        flip_pc      = 5;
`endif
        fetch(5'd5);
        fetch(5'd6);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
